// File: rtl/interp_pkg.sv
// Shared definitions for the interpolator datapath: feeder FSM encoding,
// default widths and breakpoint bank geometry.
package interp_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } feeder_state_t;

    localparam int unsigned DEF_X_WIDTH      = 8;
    localparam int unsigned DEF_WEIGHT_WIDTH = 10;
    localparam int unsigned NUM_BREAKPOINTS  = 8;
    localparam int unsigned BP_IDX_WIDTH     = 3;

    function automatic logic state_is_busy(input feeder_state_t s);
        return s != ST_RUN;
    endfunction

endpackage

// File: rtl/interp_sample_fifo.sv
// Synchronous FIFO with first-word fall-through head; DEPTH must be a power of 2
// so the pointers wrap naturally.
module interp_sample_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/interp_sample_feeder.sv
// Feeds x samples to linear_interpolator_2d and owns its breakpoint weights;
// a commit drains queued samples before the shadow bank becomes active.
module interp_sample_feeder
    import interp_pkg::*;
#(
    parameter int unsigned X_WIDTH      = DEF_X_WIDTH,
    parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cfg_we,
    input  logic [BP_IDX_WIDTH-1:0] i_cfg_addr,
    input  logic [WEIGHT_WIDTH-1:0] i_cfg_wdata,
    input  logic                    i_cfg_commit,
    output logic                    o_cfg_busy,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [X_WIDTH-1:0]      i_x,
    input  logic                    i_stall,
    output logic                    o_en,
    output logic [X_WIDTH-1:0]      o_x,
    output logic [WEIGHT_WIDTH-1:0] o_weight0,
    output logic [WEIGHT_WIDTH-1:0] o_weight1,
    output logic [WEIGHT_WIDTH-1:0] o_weight2,
    output logic [WEIGHT_WIDTH-1:0] o_weight3,
    output logic [WEIGHT_WIDTH-1:0] o_weight4,
    output logic [WEIGHT_WIDTH-1:0] o_weight5,
    output logic [WEIGHT_WIDTH-1:0] o_weight6,
    output logic [WEIGHT_WIDTH-1:0] o_weight7
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    feeder_state_t state;
    feeder_state_t next_state;

    logic [WEIGHT_WIDTH-1:0] shadow [NUM_BREAKPOINTS];
    logic [WEIGHT_WIDTH-1:0] active [NUM_BREAKPOINTS];

    logic [X_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    interp_sample_fifo #(
        .WIDTH (X_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (i_x),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready ignores a same-cycle pop so it never depends on i_stall.
    assign o_ready    = (state == ST_RUN) && !fifo_full && !rst;
    assign o_cfg_busy = state_is_busy(state) && !rst;
    assign push       = i_valid && o_ready;
    assign pop        = !fifo_empty && !i_stall && (state != ST_SWAP);

    always_comb begin
        next_state = state;
        unique case (state)
            ST_RUN:   if (i_cfg_commit) next_state = ST_DRAIN;
            ST_DRAIN: if (fifo_count == '0) next_state = ST_SWAP;
            ST_SWAP:  next_state = ST_RUN;
            default:  next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            shadow <= '{default: '0};
            active <= '{default: '0};
            o_en   <= 1'b0;
            o_x    <= '0;
        end else begin
            state <= next_state;
            if ((state == ST_RUN) && i_cfg_we) begin
                shadow[i_cfg_addr] <= i_cfg_wdata;
            end
            if (state == ST_SWAP) begin
                active <= shadow;
            end
            o_en <= pop;
            if (pop) begin
                o_x <= fifo_head;
            end
        end
    end

    assign o_weight0 = active[0];
    assign o_weight1 = active[1];
    assign o_weight2 = active[2];
    assign o_weight3 = active[3];
    assign o_weight4 = active[4];
    assign o_weight5 = active[5];
    assign o_weight6 = active[6];
    assign o_weight7 = active[7];

endmodule
